// File: rtl/stop_watch_if.sv
// Button-pulse inputs, recall address and display/LED outputs of the
// stopwatch core, bundled so the debouncer side and the display side
// connect through a single port.
interface stop_watch_if;
  logic        start_stop;
  logic        pause_resume;
  logic        record_recall;
  logic        recall_mode;
  logic [3:0]  reg_address;
  logic        reg_exceed;
  logic        started_LED;
  logic        paused_LED;
  logic [23:0] result;

  // Driver side: debouncers and the display controller.
  modport master (
    output start_stop, pause_resume, record_recall, recall_mode, reg_address,
    input  reg_exceed, started_LED, paused_LED, result
  );

  // Stopwatch core side.
  modport slave (
    input  start_stop, pause_resume, record_recall, recall_mode, reg_address,
    output reg_exceed, started_LED, paused_LED, result
  );
endinterface

// File: rtl/stop_watch.sv
// Centisecond stopwatch: MM:SS:cc kept as six BCD digits, start/stop,
// pause/resume, and a 16-entry lap file that can be viewed in recall mode
// while the clock keeps running in the background.
module stop_watch #(
  parameter int TICK_DIV = 500000
) (
  input logic         clk,
  input logic         rst,
  stop_watch_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t        state;
  logic [23:0]   time_q;
  logic [PW-1:0] pre;
  logic [4:0]    lap_count;
  logic [23:0]   laps [16];
  logic          recall;

  logic          tick;
  logic          counting;
  logic          can_record;

  // One centisecond step with BCD carries; 59:59:99 rolls over to zero.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    logic        carry;
    logic [3:0]  lim;
    n     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (n[i*4 +: 4] == lim) begin
          n[i*4 +: 4] = 4'd0;
        end else begin
          n[i*4 +: 4] = n[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // Counting runs only in RUNNING on cycles that do not change state;
  // a stop or pause edge freezes time and prescaler exactly where they are.
  assign counting   = (state == RUNNING) && !bus.start_stop && !bus.pause_resume;
  assign tick       = counting && (pre == PRE_LAST);
  assign can_record = (state != IDLE) && !bus.start_stop && !bus.pause_resume &&
                      bus.record_recall && !recall && (lap_count < 5'd16);

  // FSM, timebase, time digits, lap file and recall flag.
  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a lap therefore captures the time before any same-edge tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      time_q    <= '0;
      pre       <= '0;
      lap_count <= '0;
      recall    <= 1'b0;
      // NOTE: the lap file is cleared on reset so unused entries read as zero;
      // this costs a reset on every storage bit, accepted for the small file.
      for (int i = 0; i < 16; i++) laps[i] <= '0;
    end else begin
      if (bus.recall_mode) recall <= ~recall;

      unique case (state)
        IDLE: begin
          if (bus.start_stop) begin
            state     <= RUNNING;
            time_q    <= '0;
            pre       <= '0;
            lap_count <= '0;
          end
        end
        RUNNING: begin
          if (bus.start_stop)        state <= IDLE;
          else if (bus.pause_resume) state <= PAUSED;
        end
        PAUSED: begin
          if (bus.start_stop)        state <= IDLE;
          else if (bus.pause_resume) state <= RUNNING;
        end
        default: state <= IDLE;
      endcase

      if (counting) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) time_q <= bcd_inc(time_q);
      end

      if (can_record) begin
        laps[lap_count[3:0]] <= time_q;
        lap_count            <= lap_count + 5'd1;
      end
    end
  end

  // Display mux and status decode, all combinational from registered state.
  assign bus.result      = recall ? laps[bus.reg_address] : time_q;
  assign bus.reg_exceed  = recall && ({1'b0, bus.reg_address} >= lap_count);
  assign bus.started_LED = (state == RUNNING) || (state == PAUSED);
  assign bus.paused_LED  = (state == PAUSED);

endmodule

// File: tb/tb_stop_watch.sv
// Directed bench for the stopwatch core with a 4-cycle centisecond tick.
// Inputs change on the falling edge, outputs are sampled there too.
module tb_stop_watch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stop_watch_if sw ();

  stop_watch #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the selected pulses for exactly one rising edge.
  task automatic pulse(input logic ss, input logic pr, input logic rr, input logic rm);
    sw.start_stop    = ss;
    sw.pause_resume  = pr;
    sw.record_recall = rr;
    sw.recall_mode   = rm;
    @(negedge clk);
    sw.start_stop    = 1'b0;
    sw.pause_resume  = 1'b0;
    sw.record_recall = 1'b0;
    sw.recall_mode   = 1'b0;
  endtask

  task automatic leds(input string tag, input logic s, input logic p);
    check({tag, "_started"}, {23'd0, sw.started_LED}, {23'd0, s});
    check({tag, "_paused"},  {23'd0, sw.paused_LED},  {23'd0, p});
  endtask

  initial begin
    sw.start_stop    = 1'b0;
    sw.pause_resume  = 1'b0;
    sw.record_recall = 1'b0;
    sw.recall_mode   = 1'b0;
    sw.reg_address   = 4'd0;

    // Power-on reset.
    run(2);
    check("rst_result", sw.result, 24'h000000);
    check("rst_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    leds("rst", 1'b0, 1'b0);
    rst = 1'b0;
    run(1);

    // Start and run 40 cycles: 10 ticks.
    pulse(1, 0, 0, 0);
    run(40);
    check("run40", sw.result, 24'h000010);
    leds("run40", 1'b1, 1'b0);

    // Stop holds the value; pause is ignored in IDLE.
    pulse(1, 0, 0, 0);
    check("stop_hold", sw.result, 24'h000010);
    leds("stop", 1'b0, 1'b0);
    pulse(0, 1, 0, 0);
    leds("idle_pause", 1'b0, 1'b0);

    // Restart clears, pause freezes, resume continues.
    pulse(1, 0, 0, 0);
    check("restart_clear", sw.result, 24'h000000);
    run(20);
    check("pre_pause", sw.result, 24'h000005);
    pulse(0, 1, 0, 0);
    run(100);
    check("paused_hold", sw.result, 24'h000005);
    leds("paused", 1'b1, 1'b1);
    pulse(0, 1, 0, 0);
    run(4);
    check("resumed", sw.result, 24'h000006);
    pulse(1, 0, 0, 0);
    leds("stop2", 1'b0, 1'b0);
    run(10);
    check("stop2_hold", sw.result, 24'h000006);
    pulse(1, 0, 0, 0);
    check("restart2_clear", sw.result, 24'h000000);

    // Rollover from 59:59:98 with the prescaler freshly at zero.
    force dut.time_q = 24'h595998;
    #1 release dut.time_q;
    run(4);
    check("wrap_595999", sw.result, 24'h595999);
    run(4);
    check("wrap_zero", sw.result, 24'h000000);
    run(4);
    check("wrap_continue", sw.result, 24'h000001);

    // Laps at cs=03 and cs=07, then recall view.
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    run(12);
    pulse(0, 0, 1, 0);
    run(15);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    sw.reg_address = 4'd0; #1;
    check("lap0", sw.result, 24'h000003);
    check("lap0_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    sw.reg_address = 4'd1; #1;
    check("lap1", sw.result, 24'h000007);
    check("lap1_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    sw.reg_address = 4'd2; #1;
    check("lap2", sw.result, 24'h000000);
    check("lap2_exceed", {23'd0, sw.reg_exceed}, 24'd1);
    @(negedge clk);
    pulse(0, 0, 1, 0);
    check("recall_no_record", sw.result, 24'h000000);
    check("recall_no_record_exceed", {23'd0, sw.reg_exceed}, 24'd1);
    pulse(0, 0, 0, 1);
    // Start edge E0, then 33 more edges counted so far: cs = 33/4 = 8.
    check("live_after_recall", sw.result, 24'h000008);

    // Asynchronous reset mid-run at 00:00:05, with recall view on.
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    run(20);
    check("pre_reset", sw.result, 24'h000005);
    pulse(0, 0, 0, 1);
    sw.reg_address = 4'd2; #1;
    check("pre_reset_exceed", {23'd0, sw.reg_exceed}, 24'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", sw.result, 24'h000000);
    check("async_rst_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    leds("async_rst", 1'b0, 1'b0);
    run(2);
    rst = 1'b0;
    run(20);
    check("post_rst_result", sw.result, 24'h000000);
    check("post_rst_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    leds("post_rst", 1'b0, 1'b0);

    // 17 back-to-back records: lap i holds cs = i/4, the 17th is dropped.
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    sw.reg_address = 4'd15; #1;
    check("full_lap15", sw.result, 24'h000003);
    check("full_lap15_exceed", {23'd0, sw.reg_exceed}, 24'd0);
    sw.reg_address = 4'd0; #1;
    check("full_lap0", sw.result, 24'h000000);
    sw.reg_address = 4'd4; #1;
    check("full_lap4", sw.result, 24'h000001);
    sw.reg_address = 4'd12; #1;
    check("full_lap12", sw.result, 24'h000003);
    @(negedge clk);
    pulse(0, 0, 0, 1);

    // start_stop beats pause_resume from IDLE.
    pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    leds("same_cycle", 1'b1, 1'b0);
    run(4);
    check("same_cycle_count", sw.result, 24'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: observed no finish, expected finish within budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
